// File: rtl/byte_ram_port.sv
// Byte-addressed little-endian RAM behind a valid/ready request/response pair.
// Bad accesses are rejected with rsp_err_o, and the response latency is a parameter.
module byte_ram_port #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 32768,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        mem_q [DEPTH];
  logic [DATA_W-1:0] pend_rdata_q, rsp_rdata_q;
  logic              pend_err_q, rsp_err_q;
  logic [DATA_W-1:0] raw_s, ext_s, rsp_data_s;
  logic              sign_bit_s, fill_s;
  logic              accept_s, load_rsp_s, err_s, wr_en_s;
  logic [3:0]        nbytes_s;
  logic [32:0]       addr_end_s;
  logic [AW-1:0]     idx_s;

  assign idx_s      = req_addr_i[AW-1:0];
  assign nbytes_s   = 4'd1 << req_size_i;
  // Range check is done in 33 bits so addresses near 2^32 cannot wrap back in.
  assign addr_end_s = {1'b0, req_addr_i} + {29'd0, nbytes_s};
  assign err_s      = (nbytes_s > 4'(NB))
                   || ((req_addr_i[2:0] & (nbytes_s[2:0] - 3'd1)) != 3'd0)
                   || (addr_end_s > 33'(DEPTH));

  assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
  assign accept_s    = req_valid_i & req_ready_o;
  assign wr_en_s     = accept_s & req_we_i & ~err_s;
  assign load_rsp_s  = (accept_s && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 3'd0));

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // Load path: gather the addressed bytes, then sign- or zero-fill the upper bytes.
  always_comb begin
    raw_s = '0;
    ext_s = '0;
    for (int i = 0; i < NB; i++) begin
      if (4'(i) < nbytes_s) begin
        raw_s[8*i +: 8] = mem_q[idx_s + AW'(i)];
      end else begin
        raw_s[8*i +: 8] = 8'd0;
      end
    end
    case (req_size_i)
      2'd0:    sign_bit_s = raw_s[7];
      2'd1:    sign_bit_s = raw_s[15];
      2'd2:    sign_bit_s = raw_s[31];
      default: sign_bit_s = raw_s[DATA_W-1];
    endcase
    fill_s = sign_bit_s & ~req_unsigned_i;
    for (int i = 0; i < NB; i++) begin
      if (4'(i) < nbytes_s) begin
        ext_s[8*i +: 8] = raw_s[8*i +: 8];
      end else begin
        ext_s[8*i +: 8] = {8{fill_s}};
      end
    end
    if (req_we_i || err_s) begin
      rsp_data_s = '0;
    end else begin
      rsp_data_s = ext_s;
    end
  end

  // Storage array: byte lanes written at the accept edge, never reset.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en_s && (4'(i) < nbytes_s)) begin
        mem_q[idx_s + AW'(i)] <= req_wdata_i[8*i +: 8];
      end
    end
  end

  // Next-state logic for IDLE -> (WAIT) -> RESP sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d   = 3'(LATENCY - 2);
    end else if (state_q == WAIT) begin
      if (cnt_q == 3'd0) begin
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if ((state_q == RESP) && rsp_ready_i) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State, pending result and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        pend_rdata_q <= rsp_data_s;
        pend_err_q   <= err_s;
      end
      if (load_rsp_s) begin
        rsp_rdata_q <= (LATENCY == 1) ? rsp_data_s : pend_rdata_q;
        rsp_err_q   <= (LATENCY == 1) ? err_s : pend_err_q;
      end
    end
  end
endmodule

// File: tb/tb_byte_ram_port.sv
// Scoreboard bench for byte_ram_port: one LATENCY=1 and one LATENCY=3 instance,
// both checked against a byte-array reference model.
module tb_byte_ram_port;
  localparam int DEPTH = 1024;

  logic        clk, rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [31:0] req_addr [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rdy_mode [2];
  logic [7:0]  mm [2][DEPTH];
  logic [32:0] eq0 [$];
  logic [32:0] eq1 [$];
  int          pop_cyc [$];
  logic [31:0] held;

  byte_ram_port #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_size_i(req_size[0]), .req_unsigned_i(req_unsigned[0]),
    .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  byte_ram_port #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_size_i(req_size[1]), .req_unsigned_i(req_unsigned[1]),
    .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic over a byte array; returns {err, rdata}.
  function automatic logic [32:0] model_access(input int k, input logic we, input logic [31:0] addr,
                                               input int size, input logic uns, input logic [31:0] wd);
    longint unsigned a, v;
    int nb;
    nb = 1 << size;
    a  = addr;
    if (nb > 4 || (a % nb) != 0 || a + nb > DEPTH) return {1'b1, 32'd0};
    if (we) begin
      for (int i = 0; i < nb; i++) mm[k][int'(a) + i] = wd[8*i +: 8];
      return 33'd0;
    end
    v = 0;
    for (int i = 0; i < nb; i++) v = v + (longint'(mm[k][int'(a) + i]) << (8 * i));
    if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return {1'b0, v[31:0]};
  endfunction

  task automatic push(input int k, input logic [32:0] e);
    if (k == 0) eq0.push_back(e);
    else eq1.push_back(e);
  endtask

  task automatic issue(input int k, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    int n;
    req_we[k] = we; req_addr[k] = addr; req_size[k] = size;
    req_unsigned[k] = uns; req_wdata[k] = wd; req_valid[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready[k]) begin
      tests++; fails++;
      $display("FAIL accept_timeout k=%0d: got ready=0, want 1", k);
      req_valid[k] = 1'b0;
      return;
    end
    push(k, model_access(k, we, addr, int'(size), uns, wd));
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic rand_op(input int k);
    logic [1:0] sz;
    logic [31:0] ad;
    int r;
    sz = 2'($urandom_range(0, 3));
    r  = $urandom_range(0, 9);
    if (r < 7) ad = 32'($urandom_range(0, 127));
    else if (r < 9) ad = 32'(DEPTH - 12 + int'($urandom_range(0, 15)));
    else ad = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
    issue(k, 1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic check_rsp(input int k);
    logic [32:0] e;
    if ((k == 0 && eq0.size() == 0) || (k == 1 && eq1.size() == 0)) begin
      tests++; fails++;
      $display("FAIL rsp_unexpected k=%0d: got rdata %h, want no response", k, rsp_rdata[k]);
    end else begin
      if (k == 0) e = eq0.pop_front();
      else e = eq1.pop_front();
      chk($sformatf("rsp_err_k%0d", k), 64'(rsp_err[k]), 64'(e[32]));
      chk($sformatf("rsp_rdata_k%0d", k), 64'(rsp_rdata[k]), 64'(e[31:0]));
      if (k == 0) pop_cyc.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq0.size() != 0 || eq1.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(eq0.size() + eq1.size()), 64'd0);
  endtask

  // Monitor: every completed response handshake is checked against the queue head.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && rsp_valid[k] && rsp_ready[k]) check_rsp(k);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (rdy_mode[k] == 0) rsp_ready[k] = 1'b1;
        else if (rdy_mode[k] == 1) rsp_ready[k] = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'd0; req_size[k] = 2'd0;
      req_unsigned[k] = 1'b0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b1; rdy_mode[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", 64'(req_ready[k]), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      chk("reset_rsp_err", 64'(rsp_err[k]), 64'd0);
      chk("reset_rsp_rdata", 64'(rsp_rdata[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a += 4) begin
      issue(0, 1'b1, 32'(a), 2'd2, 1'b0, $urandom);
      issue(1, 1'b1, 32'(a), 2'd2, 1'b0, $urandom);
    end
    drain();

    // Directed: store/load, byte sign handling, misalignment and range edges.
    issue(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'd0);
    issue(0, 1'b1, 32'h101, 2'd0, 1'b0, 32'h80);
    issue(0, 1'b0, 32'h101, 2'd0, 1'b0, 32'd0);
    issue(0, 1'b0, 32'h101, 2'd0, 1'b1, 32'd0);
    issue(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'd0);
    issue(0, 1'b0, 32'h100, 2'd1, 1'b0, 32'd0);
    issue(0, 1'b0, 32'h003, 2'd1, 1'b0, 32'd0);
    issue(0, 1'b1, 32'h102, 2'd2, 1'b0, 32'h11223344);
    issue(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'd0);
    issue(0, 1'b0, 32'(DEPTH - 4), 2'd2, 1'b0, 32'd0);
    issue(0, 1'b0, 32'(DEPTH), 2'd2, 1'b0, 32'd0);
    issue(0, 1'b0, 32'h000, 2'd3, 1'b0, 32'd0);
    issue(0, 1'b0, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'd0);
    drain();

    pop_cyc.delete();
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'(4 * i), 2'd2, 1'b0, 32'd0);
    drain();
    chk("burst_count", 64'(pop_cyc.size()), 64'd8);
    for (int i = 1; i < pop_cyc.size(); i++) chk("burst_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // LATENCY=3 timing and a 5-cycle response stall with a blocked store.
    rdy_mode[1] = 2; rsp_ready[1] = 1'b0;
    req_we[1] = 1'b0; req_addr[1] = 32'h100; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("lat3_ready_idle", 64'(req_ready[1]), 64'd1);
    push(1, model_access(1, 1'b0, 32'h100, 2, 1'b0, 32'd0));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("lat3_wait_ready", 64'(req_ready[1]), 64'd0);
      chk("lat3_wait_valid", 64'(rsp_valid[1]), 64'd0);
    end
    @(negedge clk);
    chk("lat3_rsp_valid", 64'(rsp_valid[1]), 64'd1);
    held = rsp_rdata[1];
    @(posedge clk); #1;
    req_we[1] = 1'b1; req_addr[1] = 32'h104; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdata_stable", 64'(rsp_rdata[1]), 64'(held));
      chk("stall_valid", 64'(rsp_valid[1]), 64'd1);
      chk("stall_no_accept", 64'(req_ready[1]), 64'd0);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b1; rdy_mode[1] = 0;
    drain();
    issue(1, 1'b0, 32'h104, 2'd2, 1'b0, 32'd0);
    drain();

    rdy_mode[0] = 1;
    for (int i = 0; i < 200; i++) rand_op(0);
    drain();
    rdy_mode[0] = 0;
    rdy_mode[1] = 1;
    for (int i = 0; i < 120; i++) rand_op(1);
    drain();
    rdy_mode[1] = 0;
    @(posedge clk); #1;

    // Reset with one instance stalled in RESP and the other waiting after a store.
    rdy_mode[0] = 2; rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'd0);
    issue(1, 1'b1, 32'h200, 2'd2, 1'b0, 32'hCAFEF00D);
    chk("pre_reset_valid", 64'(rsp_valid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drop_valid_lat1", 64'(rsp_valid[0]), 64'd0);
    chk("rst_drop_valid_lat3", 64'(rsp_valid[1]), 64'd0);
    chk("rst_ready_lat3", 64'(req_ready[1]), 64'd1);
    eq0.delete(); eq1.delete();
    rsp_ready[0] = 1'b1; rdy_mode[0] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h200, 2'd2, 1'b0, 32'd0);
    issue(1, 1'b0, 32'h202, 2'd1, 1'b1, 32'd0);
    issue(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
